// File: rtl/ain_layer_seq.sv
// ain_layer_seq: time-multiplexes one 2-input neuron datapath across a layer.
// One input pair is accepted, then each stored weight pair is issued to the
// shared datapath in turn and its result is streamed out with index/last.
// Optional build macro: AIN_SEQ_SKIP_ZERO_EN (neurons with both weights zero
// bypass the datapath and emit 0 directly).
module ain_layer_seq #(
   parameter int  NUM_NEURONS = 4,
   parameter int  DP_LATENCY  = 1,
   localparam int IDXW        = $clog2(NUM_NEURONS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [IDXW-1:0] cfg_addr,
   input  logic [3:0]      cfg_w1,
   input  logic [3:0]      cfg_w2,
   output logic            cfg_err,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_x1,
   input  logic [3:0]      in_x2,
   output logic [3:0]      dp_x1,
   output logic [3:0]      dp_x2,
   output logic [3:0]      dp_w1,
   output logic [3:0]      dp_w2,
   input  logic [4:0]      dp_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_data,
   output logic [IDXW-1:0] out_idx,
   output logic            out_last,
   output logic            busy
);

   localparam int              WCW   = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
   localparam logic [WCW-1:0]  WLAST = WCW'(DP_LATENCY - 1);
   localparam logic [IDXW-1:0] KLAST = IDXW'(NUM_NEURONS - 1);
   localparam logic [IDXW:0]   NUM_N = (IDXW + 1)'(NUM_NEURONS);
   localparam int unsigned     NN_U  = NUM_NEURONS;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] k_q, k_d;
   logic [WCW-1:0]  wcnt_q;
   logic [3:0]      x1_q, x2_q;
   logic [3:0]      w1_q [NUM_NEURONS];
   logic [3:0]      w2_q [NUM_NEURONS];
   logic [3:0]      nw1, nw2;
   logic            accept, cfg_ok, enter, skip;

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign cfg_ok    = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < NUM_N);
   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_EMIT);
   assign out_idx   = k_q;
   assign out_last  = (k_q == KLAST);

   // Next-state, next neuron index and the weight pair for the neuron being entered
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      enter   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               k_d   = '0;
               enter = 1'b1;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (wcnt_q == WLAST) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready) begin
               if (k_q == KLAST) begin
                  state_d = S_IDLE;
                  k_d     = '0;
               end else begin
                  k_d   = k_q + 1'b1;
                  enter = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A write accepted alongside the input must reach the first ISSUE,
      // so the write data bypasses the register file here.
      nw1 = w1_q[k_d];
      nw2 = w2_q[k_d];
      if (cfg_ok && (cfg_addr == k_d)) begin
         nw1 = cfg_w1;
         nw2 = cfg_w2;
      end
`ifdef AIN_SEQ_SKIP_ZERO_EN
      skip = (nw1 == '0) && (nw2 == '0);
`else
      skip = 1'b0;
`endif
      if (enter) state_d = skip ? S_EMIT : S_ISSUE;
   end

   // State register and neuron index
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Weight register file, writable only while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NN_U; i++) begin
            w1_q[i] <= '0;
            w2_q[i] <= '0;
         end
      end else if (cfg_ok) begin
         w1_q[cfg_addr] <= cfg_w1;
         w2_q[cfg_addr] <= cfg_w2;
      end
   end

   // Input latch, registered datapath operands, latency counter, result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q     <= '0;
         x2_q     <= '0;
         dp_x1    <= '0;
         dp_x2    <= '0;
         dp_w1    <= '0;
         dp_w2    <= '0;
         wcnt_q   <= '0;
         out_data <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (accept) begin
            x1_q <= in_x1;
            x2_q <= in_x2;
         end
         // Operands are loaded on entry to ISSUE, held through WAIT, else 0
         if (state_d == S_ISSUE) begin
            dp_x1 <= accept ? in_x1 : x1_q;
            dp_x2 <= accept ? in_x2 : x2_q;
            dp_w1 <= nw1;
            dp_w2 <= nw2;
         end else if (state_d != S_WAIT) begin
            dp_x1 <= '0;
            dp_x2 <= '0;
            dp_w1 <= '0;
            dp_w2 <= '0;
         end
         wcnt_q <= (state_q == S_WAIT) ? wcnt_q + 1'b1 : '0;
         if ((state_q == S_WAIT) && (state_d == S_EMIT)) begin
            out_data <= dp_result;
         end else if (enter || (state_d == S_IDLE)) begin
            out_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ain_layer_seq.sv
// Directed bench for ain_layer_seq with a registered ReLU datapath model.
// Honours AIN_SEQ_SKIP_ZERO_EN when deciding neuron-to-neuron spacing.
module tb_ain_layer_seq;

   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_err, in_valid, in_ready;
   logic [1:0] cfg_addr, out_idx;
   logic [3:0] cfg_w1, cfg_w2, in_x1, in_x2, dp_x1, dp_x2, dp_w1, dp_w2;
   logic [4:0] dp_result, out_data;
   logic       out_valid, out_ready, out_last, busy;

   logic       u5_we, u5_err, u5_in_ready, u5_out_valid, u5_out_last, u5_busy;
   logic [2:0] u5_addr, u5_out_idx;
   logic [3:0] u5_dp_x1, u5_dp_x2, u5_dp_w1, u5_dp_w2;
   logic [4:0] u5_out_data;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] tw1 [4];
   logic [3:0] tw2 [4];
   int         exp_d [4];

   always #5 clk = ~clk;

   ain_layer_seq #(.NUM_NEURONS(4), .DP_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
      .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_w1(dp_w1), .dp_w2(dp_w2),
      .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   // Five-neuron instance: lets an out-of-range address fit in cfg_addr
   ain_layer_seq #(.NUM_NEURONS(5), .DP_LATENCY(1)) dut5 (
      .clk(clk), .rst(rst), .cfg_we(u5_we), .cfg_addr(u5_addr),
      .cfg_w1(4'd1), .cfg_w2(4'd1), .cfg_err(u5_err),
      .in_valid(1'b0), .in_ready(u5_in_ready), .in_x1(4'd0), .in_x2(4'd0),
      .dp_x1(u5_dp_x1), .dp_x2(u5_dp_x2), .dp_w1(u5_dp_w1), .dp_w2(u5_dp_w2),
      .dp_result(5'd0), .out_valid(u5_out_valid), .out_ready(1'b1),
      .out_data(u5_out_data), .out_idx(u5_out_idx), .out_last(u5_out_last),
      .busy(u5_busy)
   );

   function automatic logic [4:0] relu5(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
      int s;
      s = int'($signed(a)) * int'($signed(b)) + int'($signed(c)) * int'($signed(d));
      if (s < 0) return 5'd0;
      return s[4:0];
   endfunction

   // Shared datapath model, one cycle of latency
   always @(posedge clk) dp_result <= rst ? 5'd0 : relu5(dp_x1, dp_w1, dp_x2, dp_w2);

   function automatic int exp_gap(input int i);
`ifdef AIN_SEQ_SKIP_ZERO_EN
      if (tw1[i] == 4'd0 && tw2[i] == 4'd0) return 0;
`endif
      return 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_w(input logic [1:0] a, input logic [3:0] w1, input logic [3:0] w2);
      cfg_we = 1'b1; cfg_addr = a; cfg_w1 = w1; cfg_w2 = w2;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      tw1[a] = w1; tw2[a] = w2;
      @(negedge clk);
      check("cfg_err_idle", cfg_err, 1'b0);
   endtask

   task automatic run_seq(input logic [3:0] x1, input logic [3:0] x2, input int stall_idx,
                          input bit bad_wr, input int abort_idx, input bit hold);
      int n;
      in_x1 = x1; in_x2 = x2; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      cfg_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         @(negedge clk);
         check("in_ready_busy", in_ready, 1'b0);
         if (i == 0) check("cfg_err_ok", cfg_err, 1'b0);
         if (exp_gap(i) == 0) check("skip_dp_zero", {dp_x1, dp_x2, dp_w1, dp_w2}, 16'h0);
         else check("issue_dp", {dp_x1, dp_x2, dp_w1, dp_w2}, {x1, x2, tw1[i], tw2[i]});
         if (bad_wr && i == 0) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_w1 = 4'h7; cfg_w2 = 4'h7;
         end
         while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
            if (bad_wr && i == 0 && n == 1) begin
               check("cfg_err_busy", cfg_err, 1'b1);
               cfg_we = 1'b0;
            end
         end
         check("gap", n, exp_gap(i));
         check("out_valid", out_valid, 1'b1);
         check("out_data", out_data, exp_d[i]);
         check("out_idx", out_idx, i);
         check("out_last", out_last, i == 3);
         if (bad_wr && i == 0) check("cfg_err_pulse", cfg_err, 1'b0);
         if (i == abort_idx) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int j = 0; j < 4; j++) begin tw1[j] = 4'd0; tw2[j] = 4'd0; end
            @(negedge clk);
            check("abort_valid", out_valid, 1'b0);
            check("abort_ready", in_ready, 1'b1);
            check("abort_outs", {out_idx, out_data, busy, dp_x1, dp_w1}, 0);
            @(negedge clk);
            check("abort_valid2", out_valid, 1'b0);
            return;
         end
         if (i == stall_idx) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_hold", {out_valid, out_idx, out_data}, {1'b1, 2'(i), 5'(exp_d[i])});
               check("stall_dp", {dp_x1, dp_x2, dp_w1, dp_w2}, 16'h0);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("done_ready", in_ready, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_valid", out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_w1 = '0; cfg_w2 = '0;
      in_valid = 1'b0; in_x1 = '0; in_x2 = '0; out_ready = 1'b1;
      u5_we = 1'b0; u5_addr = '0;
      for (int j = 0; j < 4; j++) begin tw1[j] = 4'd0; tw2[j] = 4'd0; end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_outs", {busy, out_valid, out_last, cfg_err, out_idx, out_data}, 0);
      check("rst_dp", {dp_x1, dp_x2, dp_w1, dp_w2}, 16'h0);
      check("rst_u5", {u5_dp_x1, u5_dp_x2, u5_dp_w1, u5_dp_w2, u5_out_data, u5_out_idx,
                       u5_out_last, u5_busy, u5_out_valid, u5_err, u5_in_ready}, 1);

      // Layer of four neurons, input (3,1)
      load_w(2'd0, 4'd1, 4'd2);
      load_w(2'd1, 4'hF, 4'hF);
      load_w(2'd2, 4'd0, 4'd1);
      load_w(2'd3, 4'd2, 4'd0);
      exp_d = '{5, 0, 1, 6};
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b0);

      // Write while busy is dropped; the next run shows weight 0 intact
      run_seq(4'd3, 4'd1, -1, 1'b1, -1, 1'b0);

      // Consumer stall at idx 1
      run_seq(4'd3, 4'd1, 1, 1'b0, -1, 1'b0);

      // Out-of-range address on the five-neuron instance
      u5_we = 1'b1; u5_addr = 3'd5;
      @(posedge clk); #1;
      u5_we = 1'b0;
      @(negedge clk);
      check("oob_err", u5_err, 1'b1);
      @(negedge clk);
      check("oob_err_clear", u5_err, 1'b0);
      u5_we = 1'b1; u5_addr = 3'd4;
      @(posedge clk); #1;
      u5_we = 1'b0;
      @(negedge clk);
      check("max_addr_ok", u5_err, 1'b0);

      // Write in the same cycle as the accept is used by the first ISSUE
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_w1 = 4'd2; cfg_w2 = 4'd2;
      tw1[0] = 4'd2; tw2[0] = 4'd2;
      exp_d = '{8, 0, 1, 6};
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b0);
      load_w(2'd0, 4'd1, 4'd2);

      // Zero weight pair at idx 1
      load_w(2'd1, 4'd0, 4'd0);
      exp_d = '{5, 0, 1, 6};
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b0);
      load_w(2'd1, 4'hF, 4'hF);

      // Back-to-back inputs with in_valid held high
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b1);
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b0);

      // Reset at idx 2 EMIT, then a fresh input sees cleared weights
      run_seq(4'd3, 4'd1, -1, 1'b0, 2, 1'b0);
      exp_d = '{0, 0, 0, 0};
      run_seq(4'd3, 4'd1, -1, 1'b0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
